// File: rtl/uart_rx_frame.sv
// UART receive framer: oversampled start detection, centre sampling of data/parity/stop,
// and one registered FIFO write (word + error flags) per received frame.
module uart_rx_frame #(
    parameter int unsigned OSR         = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_pulse,
    input  logic       rx,
    input  logic       pen,
    input  logic       eps,
    input  logic       sticky_parity,
    input  logic [1:0] wls,
    output logic       push,
    output logic [7:0] dout,
    output logic       pe,
    output logic       fe,
    output logic       bi,
    output logic       rx_busy
);

    localparam int unsigned CNT_W = $clog2(OSR);
    localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(OSR / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(OSR - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } state_e;

    state_e                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   sync_q, sync_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [2:0]               bitcnt_q, bitcnt_d;
    logic [7:0]               shift_q, shift_d;
    logic                     pbit_q, pbit_d;
    logic [1:0]               wls_q, wls_d;
    logic                     pen_q, pen_d;
    logic                     push_q, push_d;
    logic [7:0]               dout_q, dout_d;
    logic                     pe_q, pe_d;
    logic                     fe_q, fe_d;
    logic                     bi_q, bi_d;
    logic                     rx_busy_q, rx_busy_d;

    logic                     rx_s;
    logic                     exp_par;
    logic [2:0]               bit_pos;

    assign rx_s    = sync_q[SYNC_STAGES-1];
    assign bit_pos = {1'b1, wls_q} - bitcnt_q;

    // Expected parity bit; unused MSBs of shift_q are zero so the reduction covers only data.
    always_comb begin
        exp_par = 1'b0;
        case ({sticky_parity, eps})
            2'b00:   exp_par = ~(^shift_q);
            2'b01:   exp_par = ^shift_q;
            2'b10:   exp_par = 1'b1;
            default: exp_par = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        pbit_d    = pbit_q;
        wls_d     = wls_q;
        pen_d     = pen_q;
        push_d    = 1'b0;
        dout_d    = dout_q;
        pe_d      = pe_q;
        fe_d      = fe_q;
        bi_d      = bi_q;

        if (SYNC_STAGES > 1) begin
            sync_d = {sync_q[SYNC_STAGES-2:0], rx};
        end else begin
            sync_d = SYNC_STAGES'(rx);
        end

        if (baud_pulse) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                        cnt_d   = CNT_MID;
                    end
                end
                START: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (!rx_s) begin
                        state_d  = DATA;
                        cnt_d    = CNT_TOP;
                        bitcnt_d = {1'b1, wls};
                        wls_d    = wls;
                        pen_d    = pen;
                        shift_d  = 8'h00;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DATA: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        shift_d[bit_pos] = rx_s;
                        cnt_d            = CNT_TOP;
                        if (bitcnt_q != 3'd0) begin
                            bitcnt_d = bitcnt_q - 3'd1;
                        end else begin
                            state_d = pen_q ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        pbit_d  = rx_s;
                        cnt_d   = CNT_TOP;
                        state_d = STOP;
                    end
                end
                STOP: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        push_d  = 1'b1;
                        dout_d  = shift_q;
                        fe_d    = ~rx_s;
                        pe_d    = pen_q & (pbit_q != exp_par);
                        bi_d    = (shift_q == 8'h00) & (~pen_q | ~pbit_q) & ~rx_s;
                        state_d = rx_s ? IDLE : BRK_WAIT;
                    end
                end
                BRK_WAIT: begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        rx_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sync_q    <= '1;
            cnt_q     <= '0;
            bitcnt_q  <= 3'd0;
            shift_q   <= 8'h00;
            pbit_q    <= 1'b0;
            wls_q     <= 2'b00;
            pen_q     <= 1'b0;
            push_q    <= 1'b0;
            dout_q    <= 8'h00;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            bi_q      <= 1'b0;
            rx_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            pbit_q    <= pbit_d;
            wls_q     <= wls_d;
            pen_q     <= pen_d;
            push_q    <= push_d;
            dout_q    <= dout_d;
            pe_q      <= pe_d;
            fe_q      <= fe_d;
            bi_q      <= bi_d;
            rx_busy_q <= rx_busy_d;
        end
    end

    assign push    = push_q;
    assign dout    = dout_q;
    assign pe      = pe_q;
    assign fe      = fe_q;
    assign bi      = bi_q;
    assign rx_busy = rx_busy_q;

endmodule
